// File: rtl/wb_mem_resp.sv
// wb_mem_resp: Wishbone-classic responder in front of a word-addressed on-chip RAM.
// Each accepted transfer completes with one akn_out (or err_out) pulse after WAIT
// wait states; stall_out is high while a transfer is in flight.
module wb_mem_resp #(
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned WAIT  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cyc_in,
  input  logic            stb_in,
  input  logic            we_in,
  input  logic [DW/8-1:0] sel_in,
  input  logic [AW-1:0]   adr_in,
  input  logic [DW-1:0]   dat_in,
  output logic [DW-1:0]   dat_out,
  output logic            akn_out,
  output logic            err_out,
  output logic            stall_out
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned NB = DW / 8;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_next;

  logic            r_we;
  logic            r_oor;
  logic [NB-1:0]   r_sel;
  logic [IW-1:0]   r_idx;
  logic [DW-1:0]   r_wdat;
  logic [DW-1:0]   r_mem [DEPTH];

  logic [DW-1:0]   r_dat;
  logic            r_akn;
  logic            r_err;
  logic            r_stall;

  logic            w_load;
  logic            w_commit;
  logic            w_akn_next;
  logic            w_err_next;
  logic            w_stall_next;
  logic [DW-1:0]   w_dat_next;

  assign dat_out   = r_dat;
  assign akn_out   = r_akn;
  assign err_out   = r_err;
  assign stall_out = r_stall;

  // State and counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next state, commit strobe and next registered outputs. WAIT spans WAIT+1
  // cycles (counter WAIT..0) so the registered response lands one cycle after
  // the last wait state; a dropped cyc_in beats counter expiry.
  always_comb begin
    w_next       = r_state;
    w_cnt_next   = r_cnt;
    w_load       = 1'b0;
    w_commit     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (cyc_in && stb_in) begin
          w_load     = 1'b1;
          w_cnt_next = CW'(WAIT);
          w_next     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!cyc_in) begin
          w_next     = S_IDLE;
          w_cnt_next = '0;
        end else if (r_cnt == '0) begin
          w_next   = S_RESP;
          w_commit = r_we && !r_oor;
        end else begin
          w_cnt_next = CW'(r_cnt - 1'b1);
        end
      end
      S_RESP: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next     = S_IDLE;
        w_cnt_next = '0;
      end
    endcase

    w_akn_next   = (w_next == S_RESP) && !r_oor;
    w_err_next   = (w_next == S_RESP) && r_oor;
    w_stall_next = (w_next != S_IDLE);
    w_dat_next   = '0;
    if ((w_next == S_RESP) && !r_we && !r_oor) begin
      w_dat_next = r_mem[r_idx];
    end
  end

  // Registered bus outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dat   <= '0;
      r_akn   <= 1'b0;
      r_err   <= 1'b0;
      r_stall <= 1'b0;
    end else begin
      r_dat   <= w_dat_next;
      r_akn   <= w_akn_next;
      r_err   <= w_err_next;
      r_stall <= w_stall_next;
    end
  end

  // Request capture on acceptance; range check folds in the ignored low bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we   <= 1'b0;
      r_oor  <= 1'b0;
      r_sel  <= '0;
      r_idx  <= '0;
      r_wdat <= '0;
    end else if (w_load) begin
      r_we   <= we_in;
      r_oor  <= (adr_in >= AW'(DEPTH * 4));
      r_sel  <= sel_in;
      r_idx  <= adr_in[IW+1:2];
      r_wdat <= dat_in;
    end
  end

  // RAM byte-lane write on the edge entering the response cycle; never reset.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int b = 0; b < int'(NB); b++) begin
        if (r_sel[b]) begin
          r_mem[r_idx][b*8 +: 8] <= r_wdat[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_mem_resp.sv
// tb_wb_mem_resp: directed bench for wb_mem_resp with a WAIT=2 and a WAIT=0 instance.
module tb_wb_mem_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc2, stb2, cyc0, stb0;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic [31:0] dat2, dat0;
  logic        akn2, err2, stall2, akn0, err0, stall0;

  int n_pass = 0;
  int n_tot  = 0;

  typedef struct {
    bit          we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
    bit          err;
    bit          chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [19];

  wb_mem_resp #(.AW(32), .DW(32), .DEPTH(1024), .WAIT(2)) u_dut2 (
    .clk(clk), .rst(rst), .cyc_in(cyc2), .stb_in(stb2), .we_in(we), .sel_in(sel),
    .adr_in(adr), .dat_in(wdat), .dat_out(dat2), .akn_out(akn2), .err_out(err2),
    .stall_out(stall2)
  );

  wb_mem_resp #(.AW(32), .DW(32), .DEPTH(1024), .WAIT(0)) u_dut0 (
    .clk(clk), .rst(rst), .cyc_in(cyc0), .stb_in(stb0), .we_in(we), .sel_in(sel),
    .adr_in(adr), .dat_in(wdat), .dat_out(dat0), .akn_out(akn0), .err_out(err0),
    .stall_out(stall0)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endtask

  task automatic drive_req(input bit d0, input bit on);
    if (d0) begin cyc0 = on; stb0 = on; end
    else    begin cyc2 = on; stb2 = on; end
  endtask

  task automatic get(input bit d0, output logic a, output logic e, output logic s,
                     output logic [31:0] d);
    if (d0) begin a = akn0; e = err0; s = stall0; d = dat0; end
    else    begin a = akn2; e = err2; s = stall2; d = dat2; end
  endtask

  // One complete transfer; sample j is taken after edge N+j.
  task automatic xfer(input string tag, input bit d0, input bit w, input logic [3:0] s,
                      input logic [31:0] a, input logic [31:0] d, input bit exp_err,
                      input bit chk_dat, input logic [31:0] exp_dat);
    int wt = d0 ? 0 : 2;
    int first = -1;
    int na = 0, ne = 0, nz = 0;
    logic st0 = 1'b0, stl = 1'b1;
    logic [31:0] rd = '0;
    logic ga, ge, gs;
    logic [31:0] gd;
    we = w; sel = s; adr = a; wdat = d;
    drive_req(d0, 1'b1);
    for (int j = 0; j <= wt + 4; j++) begin
      @(negedge clk);
      get(d0, ga, ge, gs, gd);
      if ((ga || ge) && first < 0) begin first = j; rd = gd; end
      if (ga) na++;
      if (ge) ne++;
      if (!ga && gd !== '0) nz++;
      if (j == 0) st0 = gs;
      if (j == wt + 2) stl = gs;
      if (j == wt + 1) drive_req(d0, 1'b0);
    end
    check({tag, " resp_cycle"}, 32'(first), 32'(wt + 1));
    check({tag, " akn_count"}, 32'(na), exp_err ? 32'd0 : 32'd1);
    check({tag, " err_count"}, 32'(ne), exp_err ? 32'd1 : 32'd0);
    check({tag, " stall_rise"}, 32'(st0), 32'd1);
    check({tag, " stall_fall"}, 32'(stl), 32'd0);
    check({tag, " dat_idle_zero"}, 32'(nz), 32'd0);
    if (chk_dat) check({tag, " rdata"}, rd, exp_dat);
  endtask

  // Write on the WAIT=2 instance, dropping cyc after sample drop_j.
  task automatic abort_seq(input string tag, input int drop_j, input logic [31:0] a);
    int nr = 0;
    logic s_before = 1'b0, s_after = 1'b1;
    we = 1'b1; sel = 4'hF; adr = a; wdat = 32'hBAD0BAD0;
    drive_req(1'b0, 1'b1);
    for (int j = 0; j <= 6; j++) begin
      @(negedge clk);
      if (akn2 || err2) nr++;
      if (j == drop_j) s_before = stall2;
      if (j == drop_j + 1) s_after = stall2;
      if (j == drop_j) drive_req(1'b0, 1'b0);
    end
    check({tag, " no_response"}, 32'(nr), 32'd0);
    check({tag, " stall_before"}, 32'(s_before), 32'd1);
    check({tag, " stall_after"}, 32'(s_after), 32'd0);
  endtask

  initial begin
    vt[0]  = '{1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0};
    vt[1]  = '{1'b0, 4'h0, 32'h0000_0010, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF};
    vt[2]  = '{1'b1, 4'hF, 32'h0000_0020, 32'hAABB_CCDD, 1'b0, 1'b0, 32'h0};
    vt[3]  = '{1'b1, 4'h5, 32'h0000_0020, 32'h1122_3344, 1'b0, 1'b0, 32'h0};
    vt[4]  = '{1'b0, 4'hF, 32'h0000_0020, 32'h0,         1'b0, 1'b1, 32'hAA22_CC44};
    vt[5]  = '{1'b1, 4'hF, 32'h0000_1000, 32'h5555_5555, 1'b1, 1'b0, 32'h0};
    vt[6]  = '{1'b1, 4'hF, 32'h0000_0000, 32'h1234_5678, 1'b0, 1'b0, 32'h0};
    vt[7]  = '{1'b0, 4'hF, 32'h0000_1000, 32'h0,         1'b1, 1'b1, 32'h0};
    vt[8]  = '{1'b0, 4'hF, 32'h0000_0000, 32'h0,         1'b0, 1'b1, 32'h1234_5678};
    vt[9]  = '{1'b1, 4'hF, 32'h0000_0024, 32'h0BAD_F00D, 1'b0, 1'b0, 32'h0};
    vt[10] = '{1'b1, 4'h0, 32'h0000_0024, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0};
    vt[11] = '{1'b0, 4'h0, 32'h0000_0024, 32'h0,         1'b0, 1'b1, 32'h0BAD_F00D};
    vt[12] = '{1'b1, 4'hF, 32'h0000_0013, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0};
    vt[13] = '{1'b0, 4'h0, 32'h0000_0010, 32'h0,         1'b0, 1'b1, 32'hCAFE_F00D};
    vt[14] = '{1'b1, 4'hF, 32'h0000_0FFC, 32'h600D_CAFE, 1'b0, 1'b0, 32'h0};
    vt[15] = '{1'b0, 4'h0, 32'h0000_0FFF, 32'h0,         1'b0, 1'b1, 32'h600D_CAFE};
    vt[16] = '{1'b0, 4'h0, 32'hFFFF_FFFC, 32'h0,         1'b1, 1'b1, 32'h0};
    vt[17] = '{1'b1, 4'hF, 32'h0000_1000, 32'hEEEE_EEEE, 1'b1, 1'b0, 32'h0};
    vt[18] = '{1'b0, 4'h0, 32'h0000_0000, 32'h0,         1'b0, 1'b1, 32'h1234_5678};

    rst = 1'b1;
    cyc2 = 1'b0; stb2 = 1'b0; cyc0 = 1'b0; stb0 = 1'b0;
    we = 1'b0; sel = '0; adr = '0; wdat = '0;

    // Asynchronous reset mid-cycle, then idle with no requests.
    #2 rst = 1'b0;
    #1;
    check("reset dat2", dat2, 32'h0);
    check("reset flags2", 32'({akn2, err2, stall2}), 32'h0);
    check("reset dat0", dat0, 32'h0);
    check("reset flags0", 32'({akn0, err0, stall0}), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    begin
      int nz = 0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if ({akn2, err2, stall2, akn0, err0, stall0} != '0 || dat2 != '0 || dat0 != '0) nz++;
      end
      check("idle outputs", 32'(nz), 32'd0);
    end

    // Table-driven transfers on the WAIT=2 instance.
    for (int i = 0; i < 19; i++) begin
      xfer($sformatf("v%0d", i), 1'b0, vt[i].we, vt[i].sel, vt[i].adr, vt[i].dat,
           vt[i].err, vt[i].chk, vt[i].exp);
    end

    // Reset while a write is waiting: dropped, RAM keeps the old word.
    xfer("pre30", 1'b0, 1'b1, 4'hF, 32'h30, 32'h3030_3030, 1'b0, 1'b0, 32'h0);
    we = 1'b1; sel = 4'hF; adr = 32'h30; wdat = 32'hFFFF_0000;
    drive_req(1'b0, 1'b1);
    @(negedge clk);
    check("midrst stall_before", 32'(stall2), 32'd1);
    #2 rst = 1'b0;
    #1 check("midrst flags", 32'({akn2, err2, stall2}), 32'h0);
    @(negedge clk);
    drive_req(1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    xfer("midrst read", 1'b0, 1'b0, 4'h0, 32'h30, 32'h0, 1'b0, 1'b1, 32'h3030_3030);

    // Abort in the middle of waiting, and abort on the expiry edge.
    xfer("pre40", 1'b0, 1'b1, 4'hF, 32'h40, 32'h4040_4040, 1'b0, 1'b0, 32'h0);
    abort_seq("abort_mid", 1, 32'h40);
    xfer("abort_mid read", 1'b0, 1'b0, 4'h0, 32'h40, 32'h0, 1'b0, 1'b1, 32'h4040_4040);
    abort_seq("abort_exp", 2, 32'h40);
    xfer("abort_exp read", 1'b0, 1'b0, 4'h0, 32'h40, 32'h0, 1'b0, 1'b1, 32'h4040_4040);

    // WAIT=0 instance: single transfers, then back-to-back reads with stb held.
    xfer("w0 wr8", 1'b1, 1'b1, 4'hF, 32'h8, 32'h0808_0808, 1'b0, 1'b0, 32'h0);
    xfer("w0 wrC", 1'b1, 1'b1, 4'hF, 32'hC, 32'h0C0C_0C0C, 1'b0, 1'b0, 32'h0);
    xfer("w0 oor", 1'b1, 1'b0, 4'h0, 32'h2000, 32'h0, 1'b1, 1'b1, 32'h0);
    begin
      logic [7:0]  pat = '0;
      logic [31:0] d1 = '0, d4 = '0;
      logic        s2 = 1'b1;
      we = 1'b0; sel = 4'h0; adr = 32'h8;
      drive_req(1'b1, 1'b1);
      for (int j = 0; j < 8; j++) begin
        @(negedge clk);
        pat[j] = akn0;
        if (j == 1) d1 = dat0;
        if (j == 4) d4 = dat0;
        if (j == 2) s2 = stall0;
        if (j == 1) adr = 32'hC;
        if (j == 4) drive_req(1'b1, 1'b0);
      end
      check("b2b akn_pattern", 32'(pat), 32'h12);
      check("b2b data1", d1, 32'h0808_0808);
      check("b2b data2", d4, 32'h0C0C_0C0C);
      check("b2b resp_not_sampled", 32'(s2), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
